sat_narrow: RTL
===============

Name: sat_narrow

Overview:
- Return-path companion to the ALU add/sub unit blocks.
- Those blocks sign-extend operands and widen results by one bit; this block narrows a widened signed result back to operand width, saturating to the narrow range.
- Streams with a valid/ready handshake, registered output and a 2-entry skid buffer.
- Keeps per-item and cumulative saturation statistics.

Parameters:
- WIDE_WL, 16: input word length, signed two's complement.
- NARROW_WL, 15: output word length; must satisfy NARROW_WL < WIDE_WL.
- CNT_WL, 8: width of the saturation event counter.

Ports:
- clk  input  1  clock
- rstb  input  1  reset
- s_valid  input  1  upstream data valid
- s_ready  output  1  block can accept
- s_data  input  WIDE_WL  signed wide value
- m_valid  output  1  output data valid
- m_ready  input  1  downstream can accept
- m_data  output  NARROW_WL  narrowed or saturated value
- m_sat  output  1  m_data was saturated
- clr_stats  input  1  clear sat_cnt and sat_sticky
- sat_cnt  output  CNT_WL  saturating count of saturated items accepted
- sat_sticky  output  1  set on any saturation since last clear

Interface: reset rstb, synchronous, active-low; clock clk.

Behaviour:
- Reset (rstb=0 at posedge clk): the following take the values shown.
  - m_valid=0, m_data=0, m_sat=0.
  - sat_cnt=0, sat_sticky=0, skid empty.
  - s_ready=1.
  - Reset mid-stream discards all buffered items without emitting them.
- Handshake:
  - Input transfer when s_valid&s_ready at posedge.
  - Output transfer when m_valid&m_ready at posedge.
  - m_valid and m_data stay stable until transferred.
  - s_ready is a register output with no combinational path from m_ready.
- Narrowing: let H = s_data[WIDE_WL-1 : NARROW_WL-1].
  - All bits of H equal: m_data = s_data[NARROW_WL-1:0], sat=0.
  - Otherwise, if s_data[WIDE_WL-1]=0: m_data = max positive (0 followed by all ones), sat=1.
  - Otherwise: m_data = min negative (1 followed by all zeros), sat=1.
  - Saturation is evaluated at acceptance; the result is stored with its sat flag.
- Latency: an item accepted into an empty block appears at m_valid on the next cycle.
- Throughput: 1 item/cycle when m_ready is held high. Order is preserved and no item is dropped or duplicated.
- State machine, based on occupancy:
  - EMPTY: m_valid=0, s_ready=1.
    - Accept -> ONE.
  - ONE: output register holds an item, s_ready=1.
    - Accept with no output transfer -> TWO (new item goes to skid).
    - Accept with output transfer -> ONE (new item goes to output register).
    - Output transfer only -> EMPTY.
  - TWO: output and skid both full, s_ready=0.
    - Output transfer -> ONE (skid item moves to output register).
    - No transfer -> stay.
- Statistics:
  - Each accepted item with sat=1 increments sat_cnt, holding at all-ones (no wrap), and sets sat_sticky.
  - clr_stats=1 zeroes both counters.
  - clr_stats in the same cycle as a saturating accept: sat_cnt=1, sat_sticky=1 (the new event is counted after the clear).
  - Statistics update at input acceptance, independent of output backpressure.

Decomposition:
- Package alu_pkg:
  - occupancy enum {EMPTY, ONE, TWO}
  - function sat_narrow_f(wide value) returning {sat, narrow value}, parameterised by widths via a localparam or parameterised class-free function with explicit slicing
- One sub-module is natural: skid_buf (2-entry valid/ready register slice, parameter DW). sat_narrow instantiates it with DW = NARROW_WL+1 to carry {sat, data}.

Test Plan (defaults WIDE_WL=16, NARROW_WL=15):
- In-range values: s_data 0x1234, then 0xC000 (-16384, exact lower bound), then 0x3FFF (+16383, exact upper bound), m_ready=1.
  -> m_data 0x1234, 0x4000, 0x3FFF on consecutive cycles, each one cycle after acceptance, m_sat=0, sat_cnt=0.
- Saturation: s_data 0x7FFF, then 0x4000, then 0x8000, then 0xBFFF.
  -> m_data 0x3FFF, 0x3FFF, 0x4000, 0x4000, all with m_sat=1; sat_cnt=4, sat_sticky=1.
- Backpressure: s_valid held high with incrementing data from 0x0001; m_ready=0 for 3 cycles, then 1.
  -> s_ready drops after 2 items are accepted; output holds 0x0001 stable; after release the sequence 0x0001, 0x0002, 0x0003, ... has no gaps or duplicates.
- Counter saturation and clear: 260 inputs of 0x7FFF.
  -> sat_cnt=255 (no wrap).
  - Then clr_stats pulsed together with a saturating accept -> sat_cnt=1, sat_sticky=1.
  - Then clr_stats alone -> sat_cnt=0, sat_sticky=0.
- Reset mid-operation: reach the TWO state, assert rstb=0 for 1 cycle.
  -> next cycle m_valid=0, s_ready=1, m_data=0, sat_cnt=0; buffered items never appear on the output.

Source files
------------

// File: rtl/alu_pkg.sv
// Package shared by the ALU return-path blocks.
//
// Contents:
//   occ_e          - occupancy states of a 2-entry register slice
//   narrow_res_t   - result of a narrowing operation: {sat, value}
//   NARROW_CALC_WL - width used internally by sat_narrow_f
//   sat_narrow_f   - narrows a sign-extended wide value to narrowWl bits,
//                    clamping to the signed range of the narrow width
package alu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // Callers sign-extend their operand to this width, so one function can
    // serve every WIDE_WL/NARROW_WL pair up to 64 bits.
    localparam int NARROW_CALC_WL = 64;

    typedef struct packed {
        logic                             sat;
        logic signed [NARROW_CALC_WL-1:0] value;
    } narrow_res_t;

    // A value fits in narrowWl bits exactly when it lies in
    // [-2^(narrowWl-1), 2^(narrowWl-1)-1]; that is the same condition as the
    // discarded upper bits all matching the new sign bit. Out-of-range values
    // clamp to the nearest end of the narrow range. The returned value is
    // sign-extended; the caller keeps its low narrowWl bits.
    function automatic narrow_res_t sat_narrow_f(
        input logic signed [NARROW_CALC_WL-1:0] wideVal,
        input int                               narrowWl
    );
        narrow_res_t                      res;
        logic signed [NARROW_CALC_WL-1:0] maxVal;
        logic signed [NARROW_CALC_WL-1:0] minVal;
        maxVal = (64'sd1 <<< (narrowWl - 1)) - 64'sd1;
        minVal = -maxVal - 64'sd1;
        res.sat   = 1'b0;
        res.value = wideVal;
        if (wideVal > maxVal) begin
            res.sat   = 1'b1;
            res.value = maxVal;
        end else if (wideVal < minVal) begin
            res.sat   = 1'b1;
            res.value = minVal;
        end
        return res;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice.
//
// The output register feeds m_data_o directly; a second (skid) register
// catches the item that arrives in the cycle the downstream stalls, so the
// upstream ready can be a plain flop with no path from m_ready_i.
//
// Ports:
//   clk, rstb             - clock, synchronous active-low reset
//   s_valid_i/s_ready_o   - upstream handshake
//   s_data_i  [DW-1:0]    - upstream payload
//   m_valid_o/m_ready_i   - downstream handshake
//   m_data_o  [DW-1:0]    - downstream payload (registered)
//   accept_o              - an input transfer happens at this edge
module skid_buf
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic          accept_o
);

    occ_e          state_q, state_d;
    logic [DW-1:0] outData_q, outData_d;
    logic [DW-1:0] skidData_q, skidData_d;
    logic          sReady_q;
    logic          mValid_q;
    logic          pop;

    assign s_ready_o = sReady_q;
    assign m_valid_o = mValid_q;
    assign m_data_o  = outData_q;
    assign accept_o  = s_valid_i & sReady_q;
    assign pop       = mValid_q & m_ready_i;

    // Occupancy next-state: a new item goes straight to the output register
    // whenever that register is (or is becoming) free, otherwise to the skid.
    always_comb begin
        state_d    = state_q;
        outData_d  = outData_q;
        skidData_d = skidData_q;
        case (state_q)
            EMPTY: begin
                if (accept_o) begin
                    outData_d = s_data_i;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept_o && pop) begin
                    outData_d = s_data_i;
                end else if (accept_o) begin
                    skidData_d = s_data_i;
                    state_d    = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    outData_d = skidData_q;
                    state_d   = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake flags are registered from the next state so that neither
    // ready nor valid has a combinational path from the other side.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= EMPTY;
            outData_q  <= '0;
            skidData_q <= '0;
            sReady_q   <= 1'b1;
            mValid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            outData_q  <= outData_d;
            skidData_q <= skidData_d;
            sReady_q   <= (state_d != TWO);
            mValid_q   <= (state_d != EMPTY);
        end
    end

endmodule

// File: rtl/sat_narrow.sv
// Narrows a widened signed ALU result back to operand width with saturation,
// streaming through a 2-entry skid buffer and keeping saturation statistics.
//
// Ports:
//   clk, rstb              - clock, synchronous active-low reset
//   s_valid/s_ready        - upstream handshake
//   s_data   [WIDE_WL-1:0] - signed wide input value
//   m_valid/m_ready        - downstream handshake
//   m_data   [NARROW_WL-1:0] - narrowed or clamped value
//   m_sat                  - m_data was clamped
//   clr_stats              - clears sat_cnt and sat_sticky
//   sat_cnt  [CNT_WL-1:0]  - saturating count of clamped items accepted
//   sat_sticky             - any clamped item accepted since last clear
module sat_narrow
    import alu_pkg::*;
#(
    parameter int WIDE_WL   = 16,
    parameter int NARROW_WL = 15,
    parameter int CNT_WL    = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDE_WL-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NARROW_WL-1:0] m_data,
    output logic                 m_sat,
    input  logic                 clr_stats,
    output logic [CNT_WL-1:0]    sat_cnt,
    output logic                 sat_sticky
);

    logic [NARROW_CALC_WL-1:0]         sExt;
    narrow_res_t                       narrowRes;
    logic [NARROW_CALC_WL-NARROW_WL-1:0] unusedHiBits;
    logic [NARROW_WL:0]                skidIn;
    logic [NARROW_WL:0]                skidOut;
    logic                              accept;
    logic [CNT_WL-1:0]                 satCnt_q, satCnt_d;
    logic                              satSticky_q, satSticky_d;

    // Saturation is decided on the way in, so each stored item carries its
    // own sat flag alongside the narrowed data.
    assign sExt         = {{(NARROW_CALC_WL-WIDE_WL){s_data[WIDE_WL-1]}}, s_data};
    assign narrowRes    = sat_narrow_f(sExt, NARROW_WL);
    assign unusedHiBits = narrowRes.value[NARROW_CALC_WL-1:NARROW_WL];
    assign skidIn       = {narrowRes.sat, narrowRes.value[NARROW_WL-1:0]};

    skid_buf #(
        .DW(NARROW_WL + 1)
    ) u_skid (
        .clk       (clk),
        .rstb      (rstb),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (skidIn),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (skidOut),
        .accept_o  (accept)
    );

    assign m_sat      = skidOut[NARROW_WL];
    assign m_data     = skidOut[NARROW_WL-1:0];
    assign sat_cnt    = satCnt_q;
    assign sat_sticky = satSticky_q;

    // Clear is applied first so a clamped item accepted in the same cycle is
    // counted after it; the counter holds at all-ones instead of wrapping.
    always_comb begin
        satCnt_d    = satCnt_q;
        satSticky_d = satSticky_q;
        if (clr_stats) begin
            satCnt_d    = '0;
            satSticky_d = 1'b0;
        end
        if (accept && narrowRes.sat) begin
            satSticky_d = 1'b1;
            if (satCnt_d != '1) begin
                satCnt_d = satCnt_d + CNT_WL'(1);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            satCnt_q    <= '0;
            satSticky_q <= 1'b0;
        end else begin
            satCnt_q    <= satCnt_d;
            satSticky_q <= satSticky_d;
        end
    end

endmodule
